// File: rtl/servo_slew_ramp.sv
// servo_slew_ramp: slews a clamped target pulse width by at most STEP ticks per servo frame
// and emits the frame-start strobe plus a per-frame-stable pulse width for the PWM stage.
module servo_slew_ramp #(
    parameter int W           = 16,
    parameter int FRAME_TICKS = 20000,
    parameter int MIN_PW      = 1000,
    parameter int MAX_PW      = 2000,
    parameter int RESET_PW    = 1500,
    parameter int STEP        = 10
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic [W-1:0] target_pw,
    input  logic         target_valid,
    output logic         target_ready,
    output logic [W-1:0] pw_ticks,
    output logic         frame_start,
    output logic         busy,
    output logic         at_target
);
    localparam int CW = (FRAME_TICKS > 2) ? $clog2(FRAME_TICKS) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(FRAME_TICKS - 1);
    localparam logic [W-1:0] MIN_V   = W'(MIN_PW);
    localparam logic [W-1:0] MAX_V   = W'(MAX_PW);
    localparam logic [W-1:0] RESET_V = W'(RESET_PW);
    localparam logic [W-1:0] STEP_V  = W'(STEP);

    typedef enum logic [1:0] {IDLE, RAMP_UP, RAMP_DOWN} state_t;

    state_t        state_q, state_d;
    logic [CW-1:0] frame_cnt_q, frame_cnt_d;
    logic          frame_start_q, frame_start_d;
    logic [W-1:0]  pw_q, pw_d, tgt_q, tgt_d, clamped, diff;
    logic          busy_q, busy_d, at_target_q, at_target_d;

    always_comb begin
        frame_cnt_d   = (frame_cnt_q == CNT_LAST) ? '0 : frame_cnt_q + 1'b1;
        frame_start_d = frame_cnt_q == CNT_LAST;
        clamped       = (target_pw < MIN_V) ? MIN_V : (target_pw > MAX_V) ? MAX_V : target_pw;
        tgt_d         = (target_valid && target_ready) ? clamped : tgt_q;
        diff          = (state_q == RAMP_UP) ? tgt_q - pw_q : pw_q - tgt_q;
        pw_d          = pw_q;
        // A short remaining gap snaps to the target so the ramp never overshoots.
        if (frame_start_q && state_q != IDLE)
            pw_d = (diff > STEP_V) ? ((state_q == RAMP_UP) ? pw_q + STEP_V : pw_q - STEP_V) : tgt_q;
        state_d       = (pw_d == tgt_d) ? IDLE : (pw_d < tgt_d) ? RAMP_UP : RAMP_DOWN;
        busy_d        = state_d != IDLE;
        at_target_d   = state_d == IDLE;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= IDLE;
            frame_cnt_q   <= '0;
            frame_start_q <= 1'b0;
            pw_q          <= RESET_V;
            tgt_q         <= RESET_V;
            busy_q        <= 1'b0;
            at_target_q   <= 1'b1;
        end else begin
            state_q       <= state_d;
            frame_cnt_q   <= frame_cnt_d;
            frame_start_q <= frame_start_d;
            pw_q          <= pw_d;
            tgt_q         <= tgt_d;
            busy_q        <= busy_d;
            at_target_q   <= at_target_d;
        end
    end

    assign target_ready = ~frame_start_q;
    assign pw_ticks     = pw_q;
    assign frame_start  = frame_start_q;
    assign busy         = busy_q;
    assign at_target    = at_target_q;
endmodule

// File: tb/tb_servo_slew_ramp.sv
// tb_servo_slew_ramp: directed and random stimulus against an arithmetic model of the
// slew ramp (short frames so long ramps stay cheap).
module tb_servo_slew_ramp;
    localparam int W    = 16;
    localparam int FT   = 20;
    localparam int STEP = 10;
    localparam int MINP = 1000;
    localparam int MAXP = 2000;
    localparam int RSTP = 1500;

    logic         clk = 1'b0;
    logic         rst_n = 1'b1;
    logic [W-1:0] target_pw = '0;
    logic         target_valid = 1'b0;
    logic         target_ready, frame_start, busy, at_target;
    logic [W-1:0] pw_ticks;

    int n_chk = 0, n_pass = 0;
    int m_pw, m_tgt, cyc, pw_min;

    servo_slew_ramp #(.W(W), .FRAME_TICKS(FT), .MIN_PW(MINP), .MAX_PW(MAXP),
                      .RESET_PW(RSTP), .STEP(STEP)) dut (
        .clk(clk), .rst_n(rst_n), .target_pw(target_pw), .target_valid(target_valid),
        .target_ready(target_ready), .pw_ticks(pw_ticks), .frame_start(frame_start),
        .busy(busy), .at_target(at_target)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    endtask

    // A strobe lands on every FT-th edge after reset release, never on edge 0.
    function automatic bit fs_now();
        return cyc > 0 && cyc % FT == 0;
    endfunction

    task automatic cycle(input logic v, input logic [W-1:0] t);
        bit fs;
        int d;
        target_valid = v;
        target_pw    = t;
        fs           = fs_now();
        @(posedge clk);
        if (fs) begin
            d = m_tgt - m_pw;
            if (d > STEP) d = STEP;
            if (d < -STEP) d = -STEP;
            m_pw += d;
        end else if (v) begin
            m_tgt = (t < MINP) ? MINP : (t > MAXP) ? MAXP : int'(t);
        end
        cyc++;
        #1;
        chk("pw_ticks", pw_ticks, m_pw);
        chk("frame_start", frame_start, fs_now());
        chk("target_ready", target_ready, !fs_now());
        chk("busy", busy, m_pw != m_tgt);
        chk("at_target", at_target, m_pw == m_tgt);
        if (pw_ticks < pw_min) pw_min = pw_ticks;
    endtask

    task automatic run(input int n);
        repeat (n) cycle(1'b0, W'($urandom));
    endtask

    task automatic send(input logic [W-1:0] t);
        if (fs_now()) cycle(1'b0, '0);
        cycle(1'b1, t);
        target_valid = 1'b0;
    endtask

    task automatic apply_reset();
        #2 rst_n = 1'b0;
        target_valid = 1'b0;
        m_pw  = RSTP;
        m_tgt = RSTP;
        cyc   = 0;
        #1;
        chk("rst_pw", pw_ticks, RSTP);
        chk("rst_frame_start", frame_start, 0);
        chk("rst_ready", target_ready, 1);
        chk("rst_busy", busy, 0);
        chk("rst_at_target", at_target, 1);
        @(posedge clk);
        @(posedge clk);
        #1 rst_n = 1'b1;
    endtask

    initial begin
        apply_reset();
        // Idle after release: strobe exactly FT cycles later, then every FT.
        run(FT - 1);
        chk("no_early_strobe", frame_start, 0);
        run(1);
        chk("first_strobe", frame_start, 1);
        run(FT);
        chk("second_strobe", frame_start, 1);
        chk("idle_pw", pw_ticks, RSTP);
        // Small moves finish in one frame without overshoot.
        send(1505);
        run(FT);
        chk("small_up", pw_ticks, 1505);
        send(1500);
        run(FT);
        chk("small_down", pw_ticks, 1500);
        // Full ramp to the top.
        send(2000);
        run(49 * FT);
        chk("up_49", pw_ticks, 1990);
        chk("up_49_busy", busy, 1);
        run(FT);
        chk("up_50", pw_ticks, 2000);
        chk("up_50_busy", busy, 0);
        chk("up_50_at", at_target, 1);
        // Clamped ramp to the bottom.
        apply_reset();
        pw_min = 65535;
        send(500);
        run(50 * FT);
        chk("down_50", pw_ticks, 1000);
        chk("down_min", pw_min, 1000);
        run(2 * FT);
        chk("down_hold", pw_ticks, 1000);
        // Reversal mid-ramp.
        apply_reset();
        send(2000);
        run(20 * FT);
        chk("rev_start", pw_ticks, 1700);
        send(1600);
        run(FT);
        chk("rev_1", pw_ticks, 1690);
        chk("rev_1_busy", busy, 1);
        run(8 * FT);
        chk("rev_9", pw_ticks, 1610);
        run(FT);
        chk("rev_10", pw_ticks, 1600);
        chk("rev_10_at", at_target, 1);
        // Valid held across a strobe is accepted only on the following cycle.
        while (!fs_now()) cycle(1'b0, '0);
        cycle(1'b1, 1800);
        chk("hold_no_xfer", at_target, 1);
        cycle(1'b1, 1800);
        target_valid = 1'b0;
        chk("hold_xfer", at_target, 0);
        run(3 * FT);
        chk("mid_ramp", pw_ticks, 1630);
        apply_reset();
        // Random targets, including out-of-range values and valids on strobe cycles.
        repeat (3000) cycle($urandom_range(0, 40) == 0, W'($urandom_range(0, 3000)));
        repeat (200) cycle($urandom_range(0, 3) == 0, W'($urandom));
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
